mux_rr_arbiter: RTL and testbench

// - Round-robin arbiter sharing one four_to_one_mux between four requesters.
// - Registers a one-hot grant and drives the mux select lines s[1:0] from the winning index.
// - Sits beside the mux: req[i] comes from source i, sel drives the mux selects (s1 = sel[1], s0 = sel[0]), busy qualifies mux output d.

---
 rtl/mux_arb_pkg.sv | 13 +
 rtl/rr_pick4.sv | 29 ++
 rtl/mux_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first unmasked request at or after start, wrapping 3->0.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  logic [3:0] cand;
  logic [1:0] probe;

  assign cand = req & ~mask;

  // Scan from the far end back toward start so the nearest candidate is written last.
  always_comb begin
    found = 1'b0;
    idx   = start;
    probe = start;
    for (int k = 3; k >= 0; k--) begin
      probe = start + 2'(k);
      if (cand[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the selects of a shared four_to_one_mux.
// Optional per-owner time quantum enabled by defining ARB_QUANTUM_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned QUANTUM = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             handover
);

  if (QUANTUM < 2) begin : g_bad_quantum
    $error("mux_rr_arbiter: QUANTUM must be >= 2");
  end

  arb_state_t state, state_d;
  logic [3:0] gnt_d;
  logic [1:0] sel_d;
  logic       busy_d;
  logic       handover_d;
  logic [1:0] last, last_d;

  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] pick_start;
  logic [3:0] pick_mask;
  logic       release_c;

`ifdef ARB_QUANTUM_EN
  localparam int unsigned QCNT_W = $clog2(QUANTUM);
  localparam logic [QCNT_W-1:0] QCNT_MAX = QCNT_W'(QUANTUM - 1);

  logic [QCNT_W-1:0] qcnt, qcnt_d;
  logic              force_c;

  // Quantum expiry only forces a release when someone else is waiting.
  assign force_c = (qcnt == QCNT_MAX) && (|(req & ~onehot(sel)));
`else
  logic force_c;
  assign force_c = 1'b0;
`endif

  // In GRANT the owner is sel; a releasing owner becomes the new last and is masked out.
  assign release_c  = ~req[sel] | force_c;
  assign pick_start = (state == ARB_GRANT) ? sel + 2'd1 : last + 2'd1;
  assign pick_mask  = (state == ARB_GRANT) ? onehot(sel) : 4'b0000;

  rr_pick4 u_pick (
    .req   (req),
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'b00;
      busy     <= 1'b0;
      handover <= 1'b0;
      last     <= 2'd3;
`ifdef ARB_QUANTUM_EN
      qcnt     <= '0;
`endif
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      sel      <= sel_d;
      busy     <= busy_d;
      handover <= handover_d;
      last     <= last_d;
`ifdef ARB_QUANTUM_EN
      qcnt     <= qcnt_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    sel_d      = sel;
    busy_d     = busy;
    handover_d = 1'b0;
    last_d     = last;
`ifdef ARB_QUANTUM_EN
    qcnt_d     = qcnt;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
`ifdef ARB_QUANTUM_EN
          qcnt_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (release_c) begin
          last_d = sel;
          if (pick_found) begin
            gnt_d      = onehot(pick_idx);
            sel_d      = pick_idx;
            handover_d = 1'b1;
`ifdef ARB_QUANTUM_EN
            qcnt_d     = '0;
`endif
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
          end
        end else begin
`ifdef ARB_QUANTUM_EN
          qcnt_d = (qcnt == QCNT_MAX) ? '0 : qcnt + QCNT_W'(1);
`endif
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed-vector bench for mux_rr_arbiter; quantum sequences run when ARB_QUANTUM_EN is defined.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       handover;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       ho;
  } vec_t;

  vec_t vq[$];

  mux_rr_arbiter #(.QUANTUM(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .handover (handover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] s, input logic b, input logic h);
    vec_t v;
    v.rst = r; v.req = rq; v.gnt = g; v.sel = s; v.busy = b; v.ho = h;
    vq.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] rq);
    reset = r;
    req   = rq;
    @(posedge clk);
    #1;
  endtask

  // Structural invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("inv_onehot0", 0, 8'($countones(gnt) <= 1), 8'd1);
      chk("inv_busy", 0, 8'(busy), 8'(|gnt));
      if (busy) chk("inv_sel", 0, 8'(gnt), 8'(4'b0001 << sel));
    end
  end

  initial begin
    reset = 1'b1;
    req   = 4'b1111;

    // Reset held two cycles with all requesting, then first grant.
    add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
    // Rotation 0,1,2,3,0 with one-cycle drops, wrapping 3->0.
    add(0, 4'b1111, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b1110, 4'b0010, 2'd1, 1, 1);
    add(0, 4'b1111, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b1101, 4'b0100, 2'd2, 1, 1);
    add(0, 4'b1111, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b1011, 4'b1000, 2'd3, 1, 1);
    add(0, 4'b1111, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b0111, 4'b0001, 2'd0, 1, 1);
    // Go idle, then lone requester 2 for five cycles; sel holds after release.
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0, 0);
    add(0, 4'b0000, 4'b0000, 2'd2, 0, 0);
    // Lone owner drops and reasserts: re-granted after one idle cycle.
    add(0, 4'b0001, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0001, 4'b0001, 2'd0, 1, 0);
    // Owner drops while another waits: it loses the grant.
    add(0, 4'b0011, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0010, 4'b0010, 2'd1, 1, 1);
    add(0, 4'b0011, 4'b0010, 2'd1, 1, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 1);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 0);
    // Reset mid-grant with sel=3, then requester 3 alone.
    add(1, 4'b1000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 0);
    add(0, 4'b0000, 4'b0000, 2'd3, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].req);
      chk_en = 1'b1;
      chk("gnt", i, 8'(gnt), 8'(vq[i].gnt));
      chk("sel", i, 8'(sel), 8'(vq[i].sel));
      chk("busy", i, 8'(busy), 8'(vq[i].busy));
      chk("handover", i, 8'(handover), 8'(vq[i].ho));
    end

`ifdef ARB_QUANTUM_EN
    // Two holders alternate every 8 cycles.
    step(1, 4'b1001);
    for (int c = 0; c < 24; c++) begin
      logic [3:0] eg;
      eg = (((c / 8) % 2) == 0) ? 4'b0001 : 4'b1000;
      step(0, 4'b1001);
      chk("q_gnt", c, 8'(gnt), 8'(eg));
      chk("q_handover", c, 8'(handover), 8'((c % 8 == 0) && (c > 0)));
    end
    // Lone holder keeps the grant across quantum wraps.
    step(0, 4'b0010);
    chk("q_switch", 0, 8'(gnt), 8'(4'b0010));
    chk("q_switch_ho", 0, 8'(handover), 8'd1);
    for (int c = 0; c < 20; c++) begin
      step(0, 4'b0010);
      chk("q_lone_gnt", c, 8'(gnt), 8'(4'b0010));
      chk("q_lone_ho", c, 8'(handover), 8'd0);
    end
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
